// File: rtl/demux4_reg_writer.sv
// demux4_reg_writer: steers buffered writes into four registers, with a bypassed combinational read.
module demux4_reg_writer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_select,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit_en,
    input  logic [1:0]       rd_select,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [1:0]       pending
);
    logic [1:0]       buf_sel  [2];
    logic [WIDTH-1:0] buf_data [2];
    logic [WIDTH-1:0] q        [4];
    logic             head, tail, accept, commit, young_hit, old_hit;
    assign wr_ready = rst_n && pending != 2'd2;
    assign accept   = wr_valid && wr_ready;
    assign commit   = commit_en && pending != 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            pending <= 2'd0;
            for (int i = 0; i < 4; i++) q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_sel[i]  <= 2'd0;
                buf_data[i] <= '0;
            end
        end else begin
            if (accept) begin
                buf_sel[tail]  <= wr_select;
                buf_data[tail] <= wr_data;
                tail           <= ~tail;
            end
            if (commit) begin
                q[buf_sel[head]] <= buf_data[head];
                head             <= ~head;
            end
            pending <= pending + {1'b0, accept} - {1'b0, commit};
        end
    end
    // youngest entry sits just behind tail; the older one is only live when full
    assign young_hit = pending != 2'd0 && buf_sel[~tail] == rd_select;
    assign old_hit   = pending == 2'd2 && buf_sel[head] == rd_select;
    assign rd_data   = young_hit ? buf_data[~tail] : old_hit ? buf_data[head] : q[rd_select];
    assign q0 = q[0];
    assign q1 = q[1];
    assign q2 = q[2];
    assign q3 = q[3];
endmodule

// File: doc/demux4_reg_writer.md
Name: demux4_reg_writer

Overview:
Write-side counterpart of the 4:1 select path: steers a data word into one of four WIDTH-bit holding registers, selected by a 2-bit code. It sits on the datapath write-back side. Writes enter through a 2-entry write buffer with a valid/ready handshake and drain into the registers under a commit enable. A combinational read port with buffer bypass returns the newest value for any select code.

Parameters:
WIDTH, 32, data width of each register and of the write/read data.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request present
wr_ready  output  1  block can accept a write this cycle
wr_select  input  2  target register index (00..11)
wr_data  input  WIDTH  write data
commit_en  input  1  allow the buffer head to commit this cycle (0 = stall)
rd_select  input  2  read index
rd_data  output  WIDTH  read data, bypassed (see Behaviour)
q0, q1, q2, q3  output  WIDTH  committed register contents
pending  output  2  buffer occupancy (0..2)

Behaviour:
- Reset (rst_n=0, asynchronous, overrides everything):
  - q0..q3 = 0; pending = 0; head/tail pointers = 0.
  - Buffered entries are discarded; wr_ready = 0 while rst_n is low.
  - Reset mid-operation drops all pending writes. No partial commit.
- Buffer:
  - 2-entry FIFO of {select, data}.
  - wr_ready = rst_n AND (pending < 2). It is a function of occupancy only and does not depend on commit_en.
  - Accept: wr_valid AND wr_ready at a posedge. The entry is stored at the tail, and the tail wraps 1 -> 0.
  - A full buffer does not accept, even in a cycle where it drains.
- Commit:
  - At a posedge with commit_en=1 and pending>0, the head entry is written into q[head.select] and the head pointer advances (wraps 1 -> 0).
  - Only one commit per cycle. The other three registers hold.
- Occupancy:
  - Accept and commit in the same cycle: pending is unchanged, and both pointers advance.
  - Accept only: pending +1. Commit only: pending -1.
- Latency:
  - A write accepted at edge N with an empty buffer and commit_en=1 at edge N+1 appears on q at edge N+1 (one cycle).
  - A write never commits in the same edge it is accepted.
- Ordering:
  - Entries commit in acceptance order.
  - Two pending entries with the same select commit in turn, so the later data is the final value.
- rd_data (combinational):
  - If the youngest buffered entry matches rd_select, return its data.
  - Otherwise, if the older buffered entry matches, return its data.
  - Otherwise return q[rd_select].
  - The bypass never returns a value from the wr_data input that has not yet been accepted.
- Stall: with commit_en=0 the buffer holds and q0..q3 hold. After two accepts, wr_ready drops until a commit frees a slot.
- Widths: pending is 2 bits and reaches 2 at most. No arithmetic on data; data is stored bit-exact.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles -> q0..q3=0, pending=0, wr_ready=0; release rst_n -> wr_ready=1.
2. Steer all four: commit_en=1; write sel=00/01/10/11 with data 0xA5A5A5A5/0x00000000/0xFFFFFFFF/0x12345678 on consecutive cycles -> each q updates exactly one cycle after its accept; the others unchanged; pending stays at most 1.
3. Stall and full: commit_en=0; write sel=10 data 0x11, then sel=10 data 0x22 -> pending=2, wr_ready=0, q2 unchanged, rd_select=10 gives 0x22. Hold wr_valid with data 0x33 -> not accepted. Set commit_en=1 -> q2=0x11 then 0x22; wr_ready returns 1 after the first commit.
4. Simultaneous accept and commit: pending=1 (sel=01 data 0x5), commit_en=1, write sel=11 data 0x7 in the same cycle -> pending stays 1, q1=0x5; the next cycle q3=0x7 and pending=0.
5. Bypass read: commit_en=0, write sel=00 data 0xDEAD, rd_select=00 -> rd_data=0xDEAD the cycle after accept while q0 still 0; rd_select=01 -> rd_data=q1.
6. Reset mid-operation: pending=2, assert rst_n=0 between clock edges -> q0..q3=0 and pending=0 immediately, with no clock needed; after release, no stale commit occurs.
